sram_buffer_ctrl: RTL

Controller that sequences and shares one `sram_matrix_buffer_wide` instance (128 words × ARR_WIDTH lanes × 8 bit) between a write requester (matrix loader) and a burst read requester (array feeder). It arbitrates per cycle with fair alternation under contention, and generates the active-low CSB/WEB strobes and the 7-bit address. It runs read bursts with address wrap-around and tags returning read data with valid/last aligned to the SRAM's one-cycle read latency.

---
 rtl/sram_buffer_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram_buffer_ctrl.sv
// sram_buffer_ctrl: shares one single-port SRAM between a write requester
// and a burst read requester. Arbitration is per cycle and alternates fairly
// under contention. The controller drives the active-low strobes and the
// address, and tags each read beat with valid/last one cycle after issue.
module sram_buffer_ctrl #(
  parameter int ARR_WIDTH = 16,
  parameter int DEPTH     = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ARR_WIDTH*8-1:0] wr_data,
  input  logic                   rd_start,
  input  logic [$clog2(DEPTH)-1:0] rd_base,
  input  logic [7:0]             rd_len,
  input  logic                   rd_pause,
  output logic                   rd_busy,
  output logic                   rd_done,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   sram_csb,
  output logic                   sram_web,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [ARR_WIDTH*8-1:0] sram_wdata
);

  localparam int AW = $clog2(DEPTH);

  // Side that won the most recent contended cycle.
  localparam logic LC_READ  = 1'b1;
  localparam logic LC_WRITE = 1'b0;

  typedef enum logic {IDLE, READ} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    issued_q, issued_d;
  logic [7:0]    len_q, len_d;
  logic          rv_q, rv_d;
  logic          rl_q, rl_d;
  logic          zdone_q, zdone_d;
  logic          last_cont_q, last_cont_d;

  logic rd_req, contended, wr_gnt, rd_gnt, start_ok;

  // Request/grant decode: a pending write only yields to reads when reads
  // did not win the previous contended cycle.
  always_comb begin
    rd_req    = (state_q == READ) && (issued_q < len_q) && !rd_pause;
    contended = rd_req && wr_valid;
    wr_ready  = !rd_req || (last_cont_q == LC_READ);
    wr_gnt    = wr_valid && wr_ready;
    rd_gnt    = rd_req && !wr_gnt;
    start_ok  = (state_q == IDLE) && rd_start;
  end

  // SRAM strobes and address; idle cycles park the address at zero.
  always_comb begin
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_addr  = '0;
    sram_wdata = wr_data;
    if (wr_gnt) begin
      sram_csb  = 1'b0;
      sram_web  = 1'b0;
      sram_addr = wr_addr;
    end else if (rd_gnt) begin
      sram_csb  = 1'b0;
      sram_addr = rd_ptr_q;
    end
  end

  // Next-state for burst FSM, pointers, return pipe and fairness flag.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    issued_d    = issued_q;
    len_d       = len_q;
    last_cont_d = last_cont_q;
    zdone_d     = 1'b0;
    // Return pipe mirrors the SRAM's one-cycle read latency.
    rv_d        = rd_gnt;
    rl_d        = rd_gnt && (issued_q == len_q - 8'd1);

    if (contended)
      last_cont_d = rd_gnt ? LC_READ : LC_WRITE;

    if (rd_gnt) begin
      rd_ptr_d = rd_ptr_q + 1'b1;  // natural wrap at DEPTH
      issued_d = issued_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          rd_ptr_d = rd_base;
          issued_d = 8'd0;
          len_d    = rd_len;
          if (rd_len == 8'd0) zdone_d = 1'b1;  // empty burst: done only
          else                state_d = READ;
        end
      end
      READ: begin
        // Burst ends once its final beat is on the output.
        if (rl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      issued_q    <= 8'd0;
      len_q       <= 8'd0;
      rv_q        <= 1'b0;
      rl_q        <= 1'b0;
      zdone_q     <= 1'b0;
      last_cont_q <= LC_READ;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      issued_q    <= issued_d;
      len_q       <= len_d;
      rv_q        <= rv_d;
      rl_q        <= rl_d;
      zdone_q     <= zdone_d;
      last_cont_q <= last_cont_d;
    end
  end

  // Status outputs derived from registered state.
  always_comb begin
    rd_busy   = (state_q == READ);
    out_valid = rv_q;
    out_last  = rl_q;
    rd_done   = rl_q || zdone_q;
  end

endmodule
